// File: rtl/exec_seq_ctrl.sv
// exec_seq_ctrl: execute-stage sequencer in front of the shared ALU.
// Single-cycle ops register the ALU result directly. MUL runs an iterative
// shift-add loop that borrows the ALU as its adder while the pipe is stalled.
// Optional build macro: MUL_EARLY_EXIT_EN (ends the multiply as soon as the
// remaining multiplier bits are all zero).
module exec_seq_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CNT_W   = 6,
  parameter logic [3:0]  ALU_ADD = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_operation,
  input  logic             is_mul,
  input  logic             is_write_in,
  input  logic             is_store_in,
  input  logic             is_load_in,
  input  logic             is_branch_in,
  input  logic             flush,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             is_write_out,
  output logic             is_store_out,
  output logic             is_load_out,
  output logic             is_branch_out,
  output logic             stall
);

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_count;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_is_write;
  logic               r_is_store;
  logic               r_is_load;
  logic               r_is_branch;

  logic               w_accept;
  logic [WIDTH-1:0]   w_acc_step;
  logic [WIDTH-1:0]   w_mplier_shift;
  logic               w_last_iter;
  logic               w_mul_done;

  // Handshake: accept only when idle and not being flushed this cycle.
  always_comb begin
    in_ready = (r_state == IDLE) && !flush;
    w_accept = in_valid && in_ready;
    stall    = (r_state != IDLE);
  end

  // Multiply step: conditional accumulate through the ALU, then termination test.
  always_comb begin
    w_acc_step     = r_mplier[0] ? alu_result : r_acc;
    w_mplier_shift = r_mplier >> 1;
    w_last_iter    = (r_count == CNT_W'(WIDTH - 1));
`ifdef MUL_EARLY_EXIT_EN
    w_mul_done     = w_last_iter || (w_mplier_shift == '0);
`else
    w_mul_done     = w_last_iter;
`endif
  end

  // ALU operand/function mux: pass-through when idle, accumulator add when multiplying.
  always_comb begin
    alu_a    = op1;
    alu_b    = op2;
    alu_ctrl = alu_operation;
    if (r_state == MUL_RUN) begin
      alu_a    = r_acc;
      alu_b    = r_mcand;
      alu_ctrl = ALU_ADD;
    end
  end

  // Next-state logic; flush wins over multiply completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && is_mul) w_state_nxt = MUL_RUN;
      end
      MUL_RUN: begin
        if (flush || w_mul_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath: operand capture, shift-add iteration and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_is_write  <= 1'b0;
      r_is_store  <= 1'b0;
      r_is_load   <= 1'b0;
      r_is_branch <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (!flush) begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_is_write  <= is_write_in;
              r_is_store  <= is_store_in;
              r_is_load   <= is_load_in;
              r_is_branch <= is_branch_in;
              if (is_mul) begin
                r_acc    <= '0;
                r_mcand  <= op1;
                r_mplier <= op2;
                r_count  <= '0;
              end else begin
                r_result    <= alu_result;
                r_out_valid <= 1'b1;
              end
            end
          end
          MUL_RUN: begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shift;
            r_count  <= r_count + CNT_W'(1);
            if (w_mul_done) begin
              r_result    <= w_acc_step;
              r_out_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Registered output ports.
  always_comb begin
    out_valid     = r_out_valid;
    result        = r_result;
    is_write_out  = r_is_write;
    is_store_out  = r_is_store;
    is_load_out   = r_is_load;
    is_branch_out = r_is_branch;
  end

endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Testbench for exec_seq_ctrl with a behavioural ALU and a product/latency model.
module tb_exec_seq_ctrl;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] op1 = '0;
  logic [WIDTH-1:0] op2 = '0;
  logic [3:0]       alu_operation = '0;
  logic             is_mul = 1'b0;
  logic             is_write_in = 1'b0;
  logic             is_store_in = 1'b0;
  logic             is_load_in = 1'b0;
  logic             is_branch_in = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             is_write_out;
  logic             is_store_out;
  logic             is_load_out;
  logic             is_branch_out;
  logic             stall;

  int n_vec = 0;
  int n_err = 0;

  exec_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(6), .ALU_ADD(4'b0000)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .alu_operation(alu_operation), .is_mul(is_mul),
    .is_write_in(is_write_in), .is_store_in(is_store_in),
    .is_load_in(is_load_in), .is_branch_in(is_branch_in), .flush(flush),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .out_valid(out_valid), .result(result),
    .is_write_out(is_write_out), .is_store_out(is_store_out),
    .is_load_out(is_load_out), .is_branch_out(is_branch_out), .stall(stall)
  );

  always #5 clk = ~clk;

  // Shared combinational ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others pass A.
  function automatic logic [WIDTH-1:0] alu_model(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [3:0] f);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_a, alu_b, alu_ctrl);

  // Edges from accept to out_valid for a multiply by b.
  function automatic int mul_latency(input logic [WIDTH-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int lat = 1;
    while (lat < WIDTH && (b >> lat) != 0) lat++;
    return lat;
`else
    return WIDTH;
`endif
  endfunction

  function automatic logic [3:0] flags_out();
    return {is_write_out, is_store_out, is_load_out, is_branch_out};
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [3:0] f, input logic m, input logic [3:0] fl);
    in_valid      = v;
    op1           = a;
    op2           = b;
    alu_operation = f;
    is_mul        = m;
    {is_write_in, is_store_in, is_load_in, is_branch_in} = fl;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 4'd0, 1'b0, 4'b0000);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({out_valid, stall, in_ready} !== 3'b001 || result !== '0 || flags_out() !== 4'b0000) begin
      n_err++;
      $display("FAIL reset: out_valid=%b stall=%b in_ready=%b result=%h flags=%b, want 0 0 1 0 0000",
               out_valid, stall, in_ready, result, flags_out());
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_ops();
    logic [WIDTH-1:0] a, b, exp_r;
    logic [3:0] f, fl, exp_fl;
    exp_r = '0;
    exp_fl = '0;
    for (int i = 0; i <= 24; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_vec++;
        if (out_valid !== 1'b1 || result !== exp_r || flags_out() !== exp_fl ||
            stall !== 1'b0 || in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL alu_op[%0d]: valid=%b result=%h flags=%b stall=%b rdy=%b, want 1 %h %b 0 1",
                   i - 1, out_valid, result, flags_out(), stall, in_ready, exp_r, exp_fl);
        end
      end
      if (i < 24) begin
        if (i == 0) begin
          a = 32'd7; b = 32'd5; f = 4'd0; fl = 4'b1000;
        end else begin
          a = $urandom; b = $urandom; f = 4'($urandom_range(0, 5)); fl = 4'($urandom);
        end
        drive(1'b1, a, b, f, 1'b0, fl);
        exp_r = alu_model(a, b, f);
        exp_fl = fl;
      end else begin
        drive(1'b0, '0, '0, 4'd0, 1'b0, 4'b0000);
      end
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || result !== exp_r) begin
      n_err++;
      $display("FAIL alu_pulse: valid=%b result=%h, want 0 %h", out_valid, result, exp_r);
    end
  endtask

  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [3:0] fl);
    logic [WIDTH-1:0] exp_r;
    int cycles;
    bit done;
    exp_r = a * b;
    @(negedge clk);
    drive(1'b1, a, b, 4'($urandom), 1'b1, fl);
    @(negedge clk);
    drive(1'b0, '0, '0, 4'd0, 1'b0, 4'b0000);
    n_vec++;
    if (stall !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mul_start %0d*%0d: stall=%b rdy=%b valid=%b, want 1 0 0", a, b, stall, in_ready, out_valid);
    end
    cycles = 0;
    done = 0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (out_valid === 1'b1) done = 1;
      else if (stall !== 1'b1) begin
        n_vec++;
        n_err++;
        $display("FAIL mul_stall %0d*%0d cycle %0d: stall=%b, want 1", a, b, cycles, stall);
      end
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL mul_timeout %0d*%0d: out_valid=0 after %0d cycles, want 1", a, b, cycles);
    end else if (cycles != mul_latency(b) || result !== exp_r || flags_out() !== fl || stall !== 1'b0) begin
      n_err++;
      $display("FAIL mul %h*%h: lat=%0d result=%h flags=%b stall=%b, want %0d %h %b 0",
               a, b, cycles, result, flags_out(), stall, mul_latency(b), exp_r, fl);
    end
  endtask

  task automatic test_mul();
    run_mul(32'd3, 32'd5, 4'b0000);
    run_mul(32'hFFFF_FFFF, 32'd2, 4'b1000);
    run_mul(32'h1234_5678, 32'd0, 4'b0101);
    for (int i = 0; i < 8; i++) begin
      if (i[0]) run_mul($urandom, $urandom, 4'($urandom));
      else      run_mul($urandom, 32'($urandom_range(0, 255)), 4'($urandom));
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mul_pulse: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_busy_ignore();
    int cycles;
    bit done;
    drive(1'b1, 32'd6, 32'd3, 4'd0, 1'b1, 4'b0010);
    @(negedge clk);
    drive(1'b1, 32'd10, 32'd20, 4'd0, 1'b0, 4'b0001);
    cycles = 0;
    done = 0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (out_valid === 1'b1) done = 1;
    end
    n_vec++;
    if (!done || cycles != mul_latency(32'd3) || result !== 32'd18 || flags_out() !== 4'b0010) begin
      n_err++;
      $display("FAIL busy_mul: done=%b lat=%0d result=%h flags=%b, want 1 %0d 00000012 0010",
               done, cycles, result, flags_out(), mul_latency(32'd3));
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 4'd0, 1'b0, 4'b0000);
    n_vec++;
    if (out_valid !== 1'b1 || result !== 32'd30 || flags_out() !== 4'b0001) begin
      n_err++;
      $display("FAIL busy_add: valid=%b result=%h flags=%b, want 1 0000001e 0001",
               out_valid, result, flags_out());
    end
  endtask

  task automatic test_flush();
`ifdef MUL_EARLY_EXIT_EN
    int wait_n = 1;
`else
    int wait_n = 10;
`endif
    @(negedge clk);
    drive(1'b1, 32'd6, 32'd7, 4'd0, 1'b1, 4'b0000);
    @(negedge clk);
    drive(1'b0, '0, '0, 4'd0, 1'b0, 4'b0000);
    repeat (wait_n) @(negedge clk);
    drive(1'b1, 32'd9, 32'd9, 4'd0, 1'b0, 4'b1111);
    flush = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0 || stall !== 1'b1) begin
      n_err++;
      $display("FAIL flush_ready: rdy=%b stall=%b, want 0 1", in_ready, stall);
    end
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, '0, '0, 4'd0, 1'b0, 4'b0000);
    n_vec++;
    if (out_valid !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_abort: valid=%b stall=%b, want 0 0", out_valid, stall);
    end
    repeat (40) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_quiet: valid=%b, want 0", out_valid);
      end
    end
    drive(1'b1, 32'd1, 32'd1, 4'd0, 1'b0, 4'b0000);
    @(negedge clk);
    drive(1'b0, '0, '0, 4'd0, 1'b0, 4'b0000);
    n_vec++;
    if (out_valid !== 1'b1 || result !== 32'd2) begin
      n_err++;
      $display("FAIL flush_add: valid=%b result=%h, want 1 00000002", out_valid, result);
    end
    drive(1'b1, 32'd3, 32'd4, 4'd0, 1'b0, 4'b1111);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, '0, '0, 4'd0, 1'b0, 4'b0000);
    n_vec++;
    if (out_valid !== 1'b0 || result !== 32'd2 || flags_out() !== 4'b0000) begin
      n_err++;
      $display("FAIL flush_idle: valid=%b result=%h flags=%b, want 0 00000002 0000",
               out_valid, result, flags_out());
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(1'b1, 32'd9, 32'd9, 4'd0, 1'b1, 4'b1000);
    @(negedge clk);
    drive(1'b0, '0, '0, 4'd0, 1'b0, 4'b0000);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || result !== '0 || stall !== 1'b0 || flags_out() !== 4'b0000) begin
      n_err++;
      $display("FAIL async_rst: valid=%b result=%h stall=%b flags=%b, want 0 0 0 0000",
               out_valid, result, stall, flags_out());
    end
    @(negedge clk);
    rst = 1'b0;
    run_mul(32'd4, 32'd4, 4'b0100);
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_mul();
    test_busy_ignore();
    test_flush();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
